// File: rtl/drg_ramp.sv
// drg_ramp: digital ramp generator producing the tuning word for a DDS.
// Parameters are captured into shadow registers on a one-cycle param_wen strobe.
// Default build sweeps a sawtooth; define DRG_TRIANGLE_EN for a triangle sweep.
module drg_ramp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             param_wen,
    input  logic [31:0]      src_sel,
    input  logic [WIDTH-1:0] direct_word,
    input  logic [WIDTH-1:0] ramp_start,
    input  logic [WIDTH-1:0] ramp_end,
    input  logic [WIDTH-1:0] ramp_step,
    input  logic [WIDTH-1:0] ramp_pulse,
    output logic [WIDTH-1:0] word_out,
    output logic             ramp_active,
    output logic             sweep_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [1:0]       src_q;
    logic [WIDTH-1:0] direct_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] end_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] pulse_q;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] pulse_last;
    logic [WIDTH:0]   sum_up;
    logic             sweep_next;
    logic [WIDTH-1:0] word_sel;

`ifdef DRG_TRIANGLE_EN
    logic             dir_down;
    logic             dir_down_next;
    logic [WIDTH:0]   diff_dn;
`endif

    // Only the two low select bits choose a source; the rest are ignored.
    logic unused_src_bits;
    assign unused_src_bits = &{1'b0, src_sel[31:2]};

    // A pulse setting of zero behaves exactly like one cycle per step.
    assign pulse_last = (pulse_q == '0) ? '0 : (pulse_q - WIDTH'(1));

    // One extra bit on the sum so acc+step can never silently wrap.
    assign sum_up = {1'b0, acc} + {1'b0, step_q};

`ifdef DRG_TRIANGLE_EN
    // The extra bit of the difference flags a borrow below zero.
    assign diff_dn = {1'b0, acc} - {1'b0, step_q};
`endif

    // Capture the configuration only on the strobe; inputs are ignored otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_q    <= '0;
            direct_q <= '0;
            start_q  <= '0;
            end_q    <= '0;
            step_q   <= '0;
            pulse_q  <= '0;
        end else if (param_wen) begin
            src_q    <= src_sel[1:0];
            direct_q <= direct_word;
            start_q  <= ramp_start;
            end_q    <= ramp_end;
            step_q   <= ramp_step;
            pulse_q  <= ramp_pulse;
        end
    end

    // Next-state and datapath decisions; a strobe always wins over a pending step.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sweep_next = 1'b0;
`ifdef DRG_TRIANGLE_EN
        dir_down_next = dir_down;
`endif
        if (param_wen) begin
            state_next = LOAD;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                LOAD: begin
                    acc_next = start_q;
                    cnt_next = '0;
`ifdef DRG_TRIANGLE_EN
                    dir_down_next = 1'b0;
`endif
                    if ((step_q == '0) || (start_q >= end_q)) begin
                        state_next = HOLD;
                    end else begin
                        state_next = RAMP;
                    end
                end
                RAMP: begin
                    if (cnt == pulse_last) begin
                        cnt_next = '0;
`ifdef DRG_TRIANGLE_EN
                        if (!dir_down) begin
                            if (sum_up > {1'b0, end_q}) begin
                                acc_next      = end_q;
                                dir_down_next = 1'b1;
                            end else begin
                                acc_next = sum_up[WIDTH-1:0];
                            end
                        end else begin
                            if (diff_dn[WIDTH] || (diff_dn[WIDTH-1:0] < start_q)) begin
                                acc_next      = start_q;
                                dir_down_next = 1'b0;
                                sweep_next    = 1'b1;
                            end else begin
                                acc_next = diff_dn[WIDTH-1:0];
                            end
                        end
`else
                        if (sum_up > {1'b0, end_q}) begin
                            acc_next   = start_q;
                            sweep_next = 1'b1;
                        end else begin
                            acc_next = sum_up[WIDTH-1:0];
                        end
`endif
                    end else begin
                        cnt_next = cnt + WIDTH'(1);
                    end
                end
                HOLD: begin
                    acc_next = start_q;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output source multiplexer driven from the shadow select.
    always_comb begin
        word_sel = '0;
        case (src_q)
            2'd0:    word_sel = direct_q;
            2'd1:    word_sel = acc;
            default: word_sel = '0;
        endcase
    end

    // State, accumulator and registered outputs; word_out trails acc by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            word_out    <= '0;
            ramp_active <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            cnt         <= cnt_next;
            word_out    <= word_sel;
            ramp_active <= (state_next == RAMP);
            sweep_done  <= sweep_next;
        end
    end

`ifdef DRG_TRIANGLE_EN
    // Sweep direction register, reset to counting up.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dir_down <= 1'b0;
        end else begin
            dir_down <= dir_down_next;
        end
    end
`endif

endmodule
